// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared types and constants for the instruction/data memory bus arbiter:
// FSM state encoding, grant owner encoding, bus widths and a small state
// classification helper. Imported by mem_bus_arbiter and its wait timer.
package mem_bus_arbiter_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned SEL_W = 4;

  // A fetch always reads a whole word.
  localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUS_I  = 3'd1,
    ARB_BUS_D  = 3'd2,
    ARB_RESP_I = 3'd3,
    ARB_RESP_D = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // True while a transaction is outstanding on the memory bus.
  function automatic logic is_bus_state(input arb_state_e s);
    return (s == ARB_BUS_I) || (s == ARB_BUS_D);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timer.sv
// mem_bus_arbiter_timer
// Wait-state counter for a bus transaction. Counts cycles while enabled and
// flags expiry on the cycle in which the count reaches TIMEOUT_CYCLES-1, so
// a transaction is abandoned after exactly TIMEOUT_CYCLES unacknowledged
// cycles. TIMEOUT_CYCLES=0 disables expiry. Written to be reusable by other
// bus bridges.
//   clk, rst : clock, synchronous active-high reset
//   clear    : return count to zero (held while the owner is idle)
//   enable   : a waiting cycle is in progress
//   expire   : combinational, this waiting cycle is the last one allowed
module mem_bus_arbiter_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic             TIMER_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT    = TIMER_ON ? CNT_W'(TIMEOUT_CYCLES - 1)
                                                   : {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_r;

  // Wait counter; saturates at expiry so it never wraps before being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && !expire) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = TIMER_ON && enable && (count_r == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port, variable-latency memory bus between the
// instruction fetch port (pc_reg) and the data port (MEM stage). Arbitrates
// round-robin, runs the req/ack handshake, registers returned read data,
// aborts a transaction after TIMEOUT_CYCLES unacknowledged cycles and
// requests a pipeline stall while either requester is waiting.
//   clk, rst                       : clock, synchronous active-high reset
//   if_req_i/if_addr_i             : fetch request and address
//   if_rdata_o/if_ready_o          : fetched word, one-cycle completion
//   flush_i                        : branch redirect, discards the fetch
//   mem_req_i/we/addr/sel/wdata    : data request
//   mem_rdata_o/mem_ready_o        : read data, one-cycle completion
//   bus_req/we/addr/sel/wdata_o    : memory bus command (registered)
//   bus_ack_i/bus_rdata_i          : memory bus completion and read data
//   stallreq_o                     : stall request to ctrl
//   bus_err_o                      : one-cycle timeout pulse
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_i,
  input  logic [BUS_W-1:0] if_addr_i,
  output logic [BUS_W-1:0] if_rdata_o,
  output logic             if_ready_o,
  input  logic             flush_i,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [BUS_W-1:0] mem_addr_i,
  input  logic [SEL_W-1:0] mem_sel_i,
  input  logic [BUS_W-1:0] mem_wdata_i,
  output logic [BUS_W-1:0] mem_rdata_o,
  output logic             mem_ready_o,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [BUS_W-1:0] bus_addr_o,
  output logic [SEL_W-1:0] bus_sel_o,
  output logic [BUS_W-1:0] bus_wdata_o,
  input  logic             bus_ack_i,
  input  logic [BUS_W-1:0] bus_rdata_i,
  output logic             stallreq_o,
  output logic             bus_err_o
);

  arb_state_e       state_r;
  arb_state_e       state_s;
  grant_e           last_grant_r;
  logic             discard_r;
  logic             bus_req_r;
  logic             bus_we_r;
  logic [BUS_W-1:0] bus_addr_r;
  logic [SEL_W-1:0] bus_sel_r;
  logic [BUS_W-1:0] bus_wdata_r;
  logic [BUS_W-1:0] if_rdata_r;
  logic             if_ready_r;
  logic [BUS_W-1:0] mem_rdata_r;
  logic             mem_ready_r;
  logic             bus_err_r;
  logic             if_cand_s;
  logic             grant_if_s;
  logic             grant_mem_s;
  logic             in_bus_s;
  logic             expire_s;

  // A fetch that arrives together with a redirect is stale; never grant it.
  assign if_cand_s = if_req_i & ~flush_i;
  assign in_bus_s  = is_bus_state(state_r);

  mem_bus_arbiter_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_r == ARB_IDLE),
    .enable (in_bus_s & ~bus_ack_i),
    .expire (expire_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Arbitration and next-state logic.
  always_comb begin
    state_s     = state_r;
    grant_if_s  = 1'b0;
    grant_mem_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (if_cand_s && mem_req_i) begin
          // Round-robin: the side not served last wins a tie.
          if (last_grant_r == GRANT_IF) begin
            grant_mem_s = 1'b1;
          end else begin
            grant_if_s = 1'b1;
          end
        end else if (if_cand_s) begin
          grant_if_s = 1'b1;
        end else if (mem_req_i) begin
          grant_mem_s = 1'b1;
        end else begin
          grant_if_s = 1'b0;
        end
        if (grant_if_s) begin
          state_s = ARB_BUS_I;
        end else if (grant_mem_s) begin
          state_s = ARB_BUS_D;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_BUS_I: begin
        if (bus_ack_i || expire_s) begin
          state_s = ARB_RESP_I;
        end else begin
          state_s = ARB_BUS_I;
        end
      end
      ARB_BUS_D: begin
        if (bus_ack_i || expire_s) begin
          state_s = ARB_RESP_D;
        end else begin
          state_s = ARB_BUS_D;
        end
      end
      ARB_RESP_I: state_s = ARB_IDLE;
      ARB_RESP_D: state_s = ARB_IDLE;
      default:    state_s = ARB_IDLE;
    endcase
  end

  // Bus command, response data and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GRANT_IF;
      discard_r    <= 1'b0;
      bus_req_r    <= 1'b0;
      bus_we_r     <= 1'b0;
      bus_addr_r   <= 32'h0000_0000;
      bus_sel_r    <= 4'h0;
      bus_wdata_r  <= 32'h0000_0000;
      if_rdata_r   <= 32'h0000_0000;
      if_ready_r   <= 1'b0;
      mem_rdata_r  <= 32'h0000_0000;
      mem_ready_r  <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      bus_err_r   <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (grant_if_s) begin
            bus_req_r    <= 1'b1;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= if_addr_i;
            bus_sel_r    <= SEL_ALL;
            bus_wdata_r  <= 32'h0000_0000;
            last_grant_r <= GRANT_IF;
          end else if (grant_mem_s) begin
            bus_req_r    <= 1'b1;
            bus_we_r     <= mem_we_i;
            bus_addr_r   <= mem_addr_i;
            bus_sel_r    <= mem_sel_i;
            bus_wdata_r  <= mem_wdata_i;
            last_grant_r <= GRANT_MEM;
          end else begin
            bus_req_r <= 1'b0;
          end
        end
        ARB_BUS_I: begin
          // The bus cannot abort, so a redirect only marks the result stale.
          if (flush_i) begin
            discard_r <= 1'b1;
          end
          if (bus_ack_i || expire_s) begin
            bus_req_r  <= 1'b0;
            if_rdata_r <= bus_ack_i ? bus_rdata_i : 32'h0000_0000;
            if_ready_r <= ~(discard_r | flush_i);
            bus_err_r  <= ~bus_ack_i;
          end
        end
        ARB_BUS_D: begin
          if (bus_ack_i || expire_s) begin
            bus_req_r   <= 1'b0;
            mem_rdata_r <= bus_ack_i ? bus_rdata_i : 32'h0000_0000;
            mem_ready_r <= 1'b1;
            bus_err_r   <= ~bus_ack_i;
          end
        end
        ARB_RESP_I: discard_r <= 1'b0;
        ARB_RESP_D: discard_r <= discard_r;
        default:    discard_r <= 1'b0;
      endcase
    end
  end

  assign bus_req_o   = bus_req_r;
  assign bus_we_o    = bus_we_r;
  assign bus_addr_o  = bus_addr_r;
  assign bus_sel_o   = bus_sel_r;
  assign bus_wdata_o = bus_wdata_r;
  assign if_rdata_o  = if_rdata_r;
  assign mem_rdata_o = mem_rdata_r;
  assign mem_ready_o = mem_ready_r;
  assign bus_err_o   = bus_err_r;

  // A redirect landing in the response cycle itself must still hide the
  // stale fetch, which the registered pulse alone cannot see in time.
  assign if_ready_o  = if_ready_r & ~flush_i;

  assign stallreq_o  = (if_req_i & ~if_ready_o & ~flush_i) |
                       (mem_req_i & ~mem_ready_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES=4). A table of
// single transactions plus hand-written sequences for arbitration order,
// flush, timeout and reset. Completions are matched against a scoreboard
// queue filled when each request is driven.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, flush_i, mem_req_i, mem_we_i, bus_ack_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ready_o, mem_ready_o, bus_req_o, bus_we_o, stallreq_o, bus_err_o;
  logic [3:0]  bus_sel_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_mem;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[5];

  // Bus responder controls.
  int          resp_waits = 0;
  logic [31:0] resp_rdata = 32'h0;
  logic        resp_en    = 1'b0;
  logic        stray_ack  = 1'b0;
  int          busc       = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ready_o(if_ready_o), .flush_i(flush_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_ready_o(mem_ready_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: acks after resp_waits extra BUS cycles, ack held negedge to negedge.
  always @(negedge clk) begin
    if (bus_ack_i) begin
      bus_ack_i = 1'b0;
      busc      = 0;
    end else if (stray_ack) begin
      bus_ack_i = 1'b1;
      stray_ack = 1'b0;
    end else if (bus_req_o && resp_en) begin
      busc = busc + 1;
      if (busc > resp_waits) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = resp_rdata;
      end
    end else begin
      busc = 0;
    end
  end

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_ready_o) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_if_ready: got pulse, required none");
      end else begin
        e = sb_q.pop_front();
        chk("if_ready_port_order", 32'(e.is_mem), 32'd0);
        chk("if_rdata", if_rdata_o, e.rdata);
      end
    end
    if (mem_ready_o) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_mem_ready: got pulse, required none");
      end else begin
        e = sb_q.pop_front();
        chk("mem_ready_port_order", 32'(e.is_mem), 32'd1);
        chk("mem_rdata", mem_rdata_o, e.rdata);
      end
    end
  end

  // One transaction; called at posedge+1, returns at posedge+1 after completion.
  task automatic do_txn(input vec_t v);
    int   cyc;
    logic got;
    exp_t e;
    resp_waits = v.waits; resp_rdata = v.rdata; resp_en = 1'b1;
    e.is_mem = v.is_mem; e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    if (v.is_mem) begin
      mem_req_i = 1'b1; mem_we_i = v.we; mem_addr_i = v.addr;
      mem_sel_i = v.sel; mem_wdata_i = v.wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = v.addr;
    end
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (if_ready_o || mem_ready_o) begin
        got = 1'b1;
        chk({v.name, "_latency"}, 32'(cyc), 32'(v.exp_lat));
        chk({v.name, "_stall_at_ready"}, 32'(stallreq_o), 32'd0);
      end else begin
        chk({v.name, "_stall_waiting"}, 32'(stallreq_o), 32'd1);
        if (bus_req_o) begin
          chk({v.name, "_bus_addr"}, bus_addr_o, v.addr);
          chk({v.name, "_bus_we"}, 32'(bus_we_o), v.is_mem ? 32'(v.we) : 32'd0);
          chk({v.name, "_bus_sel"}, 32'(bus_sel_o), v.is_mem ? 32'(v.sel) : 32'hF);
          if (v.is_mem) chk({v.name, "_bus_wdata"}, bus_wdata_o, v.wdata);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no ready in 40 cycles, required ready", v.name);
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
  endtask

  // Simultaneous fetch and data request; checks grant order and completion order.
  task automatic do_pair(input string name, input logic [31:0] ia, input logic [31:0] ma,
                         input logic mwe, input logic [3:0] msel, input logic [31:0] mwd,
                         input logic [31:0] rd, input logic mem_first);
    exp_t e;
    int   gi;
    logic prev, d_if, d_mem, done_if, done_mem, exp_mem;
    resp_waits = 0; resp_rdata = rd; resp_en = 1'b1;
    e.rdata = rd;
    e.is_mem = mem_first;  sb_q.push_back(e);
    e.is_mem = ~mem_first; sb_q.push_back(e);
    if_req_i = 1'b1; if_addr_i = ia;
    mem_req_i = 1'b1; mem_we_i = mwe; mem_addr_i = ma; mem_sel_i = msel; mem_wdata_i = mwd;
    gi = 0; prev = 1'b0; done_if = 1'b0; done_mem = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_if && done_mem) break;
      @(negedge clk);
      if (bus_req_o && !prev) begin
        gi++;
        exp_mem = (gi == 1) ? mem_first : ~mem_first;
        if (exp_mem) begin
          chk({name, "_mem_grant_addr"}, bus_addr_o, ma);
          chk({name, "_mem_grant_we"}, 32'(bus_we_o), 32'(mwe));
          chk({name, "_mem_grant_sel"}, 32'(bus_sel_o), 32'(msel));
        end else begin
          chk({name, "_if_grant_addr"}, bus_addr_o, ia);
          chk({name, "_if_grant_we"}, 32'(bus_we_o), 32'd0);
          chk({name, "_if_grant_sel"}, 32'(bus_sel_o), 32'hF);
        end
      end
      prev = bus_req_o;
      d_if = if_ready_o; d_mem = mem_ready_o;
      @(posedge clk); #1;
      if (d_if)  begin if_req_i = 1'b0;  done_if = 1'b1;  end
      if (d_mem) begin mem_req_i = 1'b0; done_mem = 1'b1; end
    end
    chk({name, "_grants"}, 32'(gi), 32'd2);
    chk({name, "_both_done"}, 32'({done_if, done_mem}), 32'd3);
    if_req_i = 1'b0; mem_req_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int   nbus, nerr, rdy_cyc, seen;
    vec_t v;

    vecs[0] = '{"if_zero_wait", 1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h3401_1100, 0, 2, 32'h3401_1100};
    vecs[1] = '{"if_three_wait", 1'b0, 1'b0, 32'h0000_0018, 4'hF, 32'h0, 32'h2402_0005, 3, 5, 32'h2402_0005};
    vecs[2] = '{"mem_wr_three_wait", 1'b1, 1'b1, 32'h0000_0300, 4'h3, 32'hDEAD_BEEF, 32'h1234_5678, 3, 5, 32'h1234_5678};
    vecs[3] = '{"if_one_wait", 1'b0, 1'b0, 32'h0000_0014, 4'hF, 32'h0, 32'h8C22_0004, 1, 3, 32'h8C22_0004};
    vecs[4] = '{"mem_rd_two_wait", 1'b1, 1'b0, 32'h0000_0404, 4'hC, 32'h0, 32'hCAFE_F00D, 2, 4, 32'hCAFE_F00D};

    rst = 1'b1; if_req_i = 1'b0; flush_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    if_addr_i = 32'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_sel_i = 4'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_bus_fields", {bus_addr_o[27:0], bus_sel_o} | bus_wdata_o | 32'(bus_we_o), 32'd0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 32'd0);
    chk("rst_pulses", 32'({if_ready_o, mem_ready_o, bus_err_o, stallreq_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_pair("pair_out_of_reset", 32'h0000_0020, 32'h0000_0100, 1'b1, 4'b0011,
            32'hDEAD_BEEF, 32'h5555_AAAA, 1'b1);

    for (int i = 0; i < 5; i++) begin
      do_txn(vecs[i]);
    end

    // Last grant was data, so a tie now goes to the fetch port.
    do_pair("pair_after_data", 32'h0000_0024, 32'h0000_0104, 1'b0, 4'hF,
            32'h0, 32'h0BAD_F00D, 1'b0);

    // Flush mid-fetch: bus completes, no fetch ready.
    resp_waits = 2; resp_rdata = 32'hFFFF_0000; resp_en = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_req_o) seen = 1;
      @(posedge clk); #1;
    end
    chk("flush_fetch_started", 32'(seen), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall_low", 32'(stallreq_o), 32'd0);
    chk("flush_bus_still_busy", 32'(bus_req_o), 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b0; if_req_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (if_ready_o) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_if_ready", 32'(seen), 32'd0);
    chk("flush_bus_done", 32'(bus_req_o), 32'd0);
    v = '{"if_after_flush", 1'b0, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 32'h0000_0123, 0, 2, 32'h0000_0123};
    do_txn(v);

    // Timeout: no ack at all.
    resp_en = 1'b0;
    begin
      exp_t e;
      e.is_mem = 1'b1; e.rdata = 32'h0;
      sb_q.push_back(e);
    end
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0500; mem_sel_i = 4'hF;
    nbus = 0; nerr = 0; rdy_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_req_o) nbus++;
      if (bus_err_o) begin
        nerr++;
        chk("timeout_err_with_ready", 32'(mem_ready_o), 32'd1);
      end
      if (mem_ready_o) rdy_cyc = c;
      @(posedge clk); #1;
      if (rdy_cyc == c) mem_req_i = 1'b0;
    end
    chk("timeout_bus_cycles", 32'(nbus), 32'd4);
    chk("timeout_err_pulses", 32'(nerr), 32'd1);
    chk("timeout_ready_cycle", 32'(rdy_cyc), 32'd5);

    // Reset during BUS_D, then a stray ack in IDLE.
    resp_en = 1'b0;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0600;
    mem_sel_i = 4'hF; mem_wdata_i = 32'h7777_7777;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_req_o) seen = 1;
      @(posedge clk); #1;
    end
    chk("rst_mid_started", 32'(seen), 32'd1);
    rst = 1'b1; mem_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; stray_ack = 1'b1;
    @(negedge clk);
    chk("rst_mid_bus_req", 32'(bus_req_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (if_ready_o || mem_ready_o || bus_req_o) seen++;
    end
    chk("rst_mid_stray_ack_ignored", 32'(seen), 32'd0);
    chk("rst_mid_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    v = '{"mem_after_reset", 1'b1, 1'b0, 32'h0000_0700, 4'hF, 32'h0, 32'h0F0F_0F0F, 0, 2, 32'h0F0F_0F0F};
    do_txn(v);
    chk("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
